// File: rtl/game_level_fsm.sv
// Game-flow controller: sequences Intro -> L1 -> NL2 -> L2 -> NL3 -> L3 -> DoneL/DoneW and counts zombie kills.
// Latency: a pulse sampled on edge N changes the registered outputs right after edge N (1 cycle).
// Backpressure: none. The inputs are one-cycle pulses, and a pulse that has no effect in the current state is dropped.
//
// Ports:
//   ClkPort        system clock
//   RESET_N        asynchronous active-low reset; release takes effect on the next ClkPort edge
//   select_pulse   BtnC pulse: start / skip pause / return to intro
//   frame_tick     one pulse per VGA frame; paces the inter-level pause
//   kill_pulse     one pulse per zombie killed
//   breach_pulse   one pulse when a zombie reaches the house
//   state          one-hot game state (I=80 L1=40 NL2=20 L2=10 NL3=08 L3=04 DoneL=02 DoneW=01)
//   level          0 in I/DoneL/DoneW, 1 in L1, 2 in NL2/L2, 3 in NL3/L3
//   spawn_en       high only while a level is being played
//   level_kills    kills in the current level (saturating)
//   zombies_killed kills since leaving I (saturating)
//   pause_left     frame ticks left in NL2/NL3, otherwise 0
module game_level_fsm #(
  parameter int unsigned KILLS_L1     = 10,
  parameter int unsigned KILLS_L2     = 15,
  parameter int unsigned KILLS_L3     = 20,
  parameter int unsigned PAUSE_FRAMES = 120
) (
  input  logic        ClkPort,
  input  logic        RESET_N,
  input  logic        select_pulse,
  input  logic        frame_tick,
  input  logic        kill_pulse,
  input  logic        breach_pulse,
  output logic [7:0]  state,
  output logic [1:0]  level,
  output logic        spawn_en,
  output logic [15:0] level_kills,
  output logic [15:0] zombies_killed,
  output logic [7:0]  pause_left
);

  typedef enum logic [7:0] {
    S_I     = 8'h80,
    S_L1    = 8'h40,
    S_NL2   = 8'h20,
    S_L2    = 8'h10,
    S_NL3   = 8'h08,
    S_L3    = 8'h04,
    S_DONEL = 8'h02,
    S_DONEW = 8'h01
  } state_e;

  // The state register is a plain vector, so any corrupted value can be held in it
  // and then caught by the default branch below.
  logic [7:0]  state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic        spawn_q, spawn_d;
  logic [15:0] lk_q, lk_d;
  logic [15:0] zk_q, zk_d;
  logic [7:0]  pl_q, pl_d;

  logic [15:0] lk_inc, zk_inc;
  logic [15:0] thresh;

  // Both counters saturate instead of wrapping.
  assign lk_inc = (lk_q == 16'hFFFF) ? lk_q : lk_q + 16'd1;
  assign zk_inc = (zk_q == 16'hFFFF) ? zk_q : zk_q + 16'd1;

  // Kill target for whichever level is being played.
  always_comb begin
    thresh = 16'(KILLS_L1);
    if (state_q == S_L2) thresh = 16'(KILLS_L2);
    if (state_q == S_L3) thresh = 16'(KILLS_L3);
  end

  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    zk_d    = zk_q;
    pl_d    = pl_q;
    case (state_q)
      S_I: begin
        if (select_pulse) begin
          state_d = S_L1;
          lk_d    = 16'd0;
          zk_d    = 16'd0;
          pl_d    = 8'd0;
        end
      end
      S_L1, S_L2, S_L3: begin
        if (kill_pulse) begin
          lk_d = lk_inc;
          zk_d = zk_inc;
        end
        // A breach outranks a kill that reaches the target in the same cycle.
        // That kill is still added to the score.
        if (breach_pulse) begin
          state_d = S_DONEL;
        end else if (kill_pulse && (lk_inc == thresh)) begin
          if (state_q == S_L1) begin
            state_d = S_NL2;
            lk_d    = 16'd0;
            pl_d    = 8'(PAUSE_FRAMES);
          end else if (state_q == S_L2) begin
            state_d = S_NL3;
            lk_d    = 16'd0;
            pl_d    = 8'(PAUSE_FRAMES);
          end else begin
            state_d = S_DONEW;
          end
        end
      end
      S_NL2, S_NL3: begin
        // The check against 1 or 0 also handles PAUSE_FRAMES=0: the first tick exits.
        if (select_pulse || (frame_tick && (pl_q <= 8'd1))) begin
          state_d = (state_q == S_NL2) ? S_L2 : S_L3;
          pl_d    = 8'd0;
        end else if (frame_tick) begin
          pl_d = pl_q - 8'd1;
        end
      end
      S_DONEL, S_DONEW: begin
        // The score stays frozen on the end screen.
        if (select_pulse) state_d = S_I;
      end
      default: begin
        // Recover from a value that is not one-hot.
        state_d = S_I;
        pl_d    = 8'd0;
      end
    endcase
  end

  // level and spawn_en are decoded from the next state, so they change on the same edge as state.
  always_comb begin
    level_d = 2'd0;
    spawn_d = 1'b0;
    case (state_d)
      S_L1:         begin level_d = 2'd1; spawn_d = 1'b1; end
      S_NL2:        level_d = 2'd2;
      S_L2:         begin level_d = 2'd2; spawn_d = 1'b1; end
      S_NL3:        level_d = 2'd3;
      S_L3:         begin level_d = 2'd3; spawn_d = 1'b1; end
      default:      begin level_d = 2'd0; spawn_d = 1'b0; end
    endcase
  end

  always_ff @(posedge ClkPort or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_I;
      level_q <= 2'd0;
      spawn_q <= 1'b0;
      lk_q    <= 16'd0;
      zk_q    <= 16'd0;
      pl_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      spawn_q <= spawn_d;
      lk_q    <= lk_d;
      zk_q    <= zk_d;
      pl_q    <= pl_d;
    end
  end

  assign state          = state_q;
  assign level          = level_q;
  assign spawn_en       = spawn_q;
  assign level_kills    = lk_q;
  assign zombies_killed = zk_q;
  assign pause_left     = pl_q;

endmodule

// File: tb/tb_game_level_fsm.sv
// Directed bench for game_level_fsm. It plays a table of single-cycle vectors,
// then runs hand-written sequences for the win, pause, mid-level reset and illegal-state recovery cases.
module tb_game_level_fsm;

  logic        ClkPort;
  logic        RESET_N;
  logic        select_pulse, frame_tick, kill_pulse, breach_pulse;
  logic [7:0]  state;
  logic [1:0]  level;
  logic        spawn_en;
  logic [15:0] level_kills, zombies_killed;
  logic [7:0]  pause_left;

  int checks   = 0;
  int failures = 0;

  game_level_fsm dut (
    .ClkPort        (ClkPort),
    .RESET_N        (RESET_N),
    .select_pulse   (select_pulse),
    .frame_tick     (frame_tick),
    .kill_pulse     (kill_pulse),
    .breach_pulse   (breach_pulse),
    .state          (state),
    .level          (level),
    .spawn_en       (spawn_en),
    .level_kills    (level_kills),
    .zombies_killed (zombies_killed),
    .pause_left     (pause_left)
  );

  initial ClkPort = 1'b0;
  always #5 ClkPort = ~ClkPort;

  typedef struct {
    logic        sel, tick, kill, brk;
    logic [7:0]  st;
    logic [1:0]  lv;
    logic        sp;
    logic [15:0] lk, zk;
    logic [7:0]  pl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sel, tick, kill, brk,
                     input logic [7:0] st, input logic [1:0] lv, input logic sp,
                     input logic [15:0] lk, zk, input logic [7:0] pl);
    vec_t v;
    v.sel = sel; v.tick = tick; v.kill = kill; v.brk = brk;
    v.st = st; v.lv = lv; v.sp = sp; v.lk = lk; v.zk = zk; v.pl = pl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] st, input logic [1:0] lv,
                           input logic sp, input logic [15:0] lk, zk, input logic [7:0] pl);
    chk({tag, ".state"},          {8'd0, state},       {8'd0, st});
    chk({tag, ".level"},          {14'd0, level},      {14'd0, lv});
    chk({tag, ".spawn_en"},       {15'd0, spawn_en},   {15'd0, sp});
    chk({tag, ".level_kills"},    level_kills,         lk);
    chk({tag, ".zombies_killed"}, zombies_killed,      zk);
    chk({tag, ".pause_left"},     {8'd0, pause_left},  {8'd0, pl});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic sel, tick, kill, brk);
    select_pulse = sel; frame_tick = tick; kill_pulse = kill; breach_pulse = brk;
    @(posedge ClkPort);
    #1;
    select_pulse = 1'b0; frame_tick = 1'b0; kill_pulse = 1'b0; breach_pulse = 1'b0;
  endtask

  task automatic kills(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1, 0);
  endtask

  initial begin
    select_pulse = 1'b0; frame_tick = 1'b0; kill_pulse = 1'b0; breach_pulse = 1'b0;
    RESET_N = 1'b1;

    // Lose path, ignored pulses, and a tie between breach and the target kill.
    //   sel tick kill brk   state  lv sp  lk  zk  pl
    add(1, 0, 0, 0, 8'h40, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 8'h40, 1, 1, 1, 1, 0);
    add(0, 0, 1, 0, 8'h40, 1, 1, 2, 2, 0);
    add(1, 0, 0, 0, 8'h40, 1, 1, 2, 2, 0);
    add(0, 1, 0, 0, 8'h40, 1, 1, 2, 2, 0);
    add(0, 0, 1, 0, 8'h40, 1, 1, 3, 3, 0);
    add(0, 0, 0, 1, 8'h02, 0, 0, 3, 3, 0);
    add(0, 0, 1, 0, 8'h02, 0, 0, 3, 3, 0);
    add(0, 1, 0, 0, 8'h02, 0, 0, 3, 3, 0);
    add(1, 0, 0, 0, 8'h80, 0, 0, 3, 3, 0);
    add(0, 0, 1, 0, 8'h80, 0, 0, 3, 3, 0);
    add(0, 0, 0, 1, 8'h80, 0, 0, 3, 3, 0);
    add(1, 0, 0, 0, 8'h40, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 1, 0, 8'h40, 1, 1, 16'(k), 16'(k), 0);
    add(0, 0, 1, 1, 8'h02, 0, 0, 10, 10, 0);
    add(1, 0, 0, 0, 8'h80, 0, 0, 10, 10, 0);

    // The reset is asserted asynchronously, before any clock edge.
    #2 RESET_N = 1'b0;
    #1 check_all("reset", 8'h80, 0, 0, 0, 0, 0);
    repeat (2) @(posedge ClkPort);
    @(negedge ClkPort) RESET_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sel, vecs[i].tick, vecs[i].kill, vecs[i].brk);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].lv, vecs[i].sp,
                vecs[i].lk, vecs[i].zk, vecs[i].pl);
    end

    // Full win, covering the pause timing and a skip with select.
    step(1, 0, 0, 0);
    check_all("win.l1", 8'h40, 1, 1, 0, 0, 0);
    kills(9);
    check_all("win.l1_9", 8'h40, 1, 1, 9, 9, 0);
    kills(1);
    check_all("win.nl2", 8'h20, 2, 0, 0, 10, 120);
    for (int t = 0; t < 119; t++) step(0, 1, 0, 0);
    check_all("pause.119", 8'h20, 2, 0, 0, 10, 1);
    step(0, 0, 1, 0);
    check_all("pause.kill_ign", 8'h20, 2, 0, 0, 10, 1);
    step(0, 0, 0, 1);
    check_all("pause.breach_ign", 8'h20, 2, 0, 0, 10, 1);
    step(0, 1, 0, 0);
    check_all("pause.120", 8'h10, 2, 1, 0, 10, 0);
    kills(15);
    check_all("win.nl3", 8'h08, 3, 0, 0, 25, 120);
    step(0, 1, 0, 0);
    check_all("win.nl3_tick", 8'h08, 3, 0, 0, 25, 119);
    step(1, 0, 0, 0);
    check_all("win.skip", 8'h04, 3, 1, 0, 25, 0);
    kills(19);
    check_all("win.l3_19", 8'h04, 3, 1, 19, 44, 0);
    kills(1);
    check_all("win.donew", 8'h01, 0, 0, 20, 45, 0);
    step(0, 0, 1, 1);
    check_all("win.hold", 8'h01, 0, 0, 20, 45, 0);

    // Reset in the middle of L2.
    step(1, 0, 0, 0);
    check_all("again.i", 8'h80, 0, 0, 20, 45, 0);
    step(1, 0, 0, 0);
    kills(10);
    step(1, 0, 0, 0);
    kills(2);
    check_all("mid.l2", 8'h10, 2, 1, 2, 12, 0);
    #1 RESET_N = 1'b0;
    #1 check_all("mid.reset", 8'h80, 0, 0, 0, 0, 0);
    @(negedge ClkPort) RESET_N = 1'b1;

    // Corrupt the state register and expect recovery to I on the next clock.
    step(0, 0, 0, 0);
    force dut.state_q = 8'h41;
    #1 release dut.state_q;
    step(0, 0, 0, 0);
    chk("illegal.recover", {8'd0, state}, 16'h0080);
    step(1, 0, 0, 0);
    chk("illegal.restart", {8'd0, state}, 16'h0040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_level_fsm.md
# game_level_fsm

Game-flow controller for the Plants vs Zombies VGA design. It owns the 8-bit one-hot game `state` bus that the top level decodes to pick between the gameplay renderer and the lose/win screens. It sequences Intro -> Level 1 -> Level 2 -> Level 3 with inter-level pauses, counts zombie kills per level and over the whole game, and gates zombie spawning. It sits between the debounced button pulses and the gameplay/VGA logic, all on `ClkPort`.

## Interface
- `KILLS_L1`, 10, kills needed to clear Level 1
- `KILLS_L2`, 15, kills needed to clear Level 2
- `KILLS_L3`, 20, kills needed to clear Level 3
- `PAUSE_FRAMES`, 120, frame ticks spent in NL2/NL3 before auto-advance (2 s at 60 Hz)

- `ClkPort`  in  1  system clock; only clock
- `RESET_N`  in  1  reset; asynchronous, active-low
- `select_pulse`  in  1  one-cycle pulse from BtnC debouncer SCEN
- `frame_tick`  in  1  one-cycle pulse per VGA frame (start of vSync)
- `kill_pulse`  in  1  one-cycle pulse per zombie killed
- `breach_pulse`  in  1  one-cycle pulse when a zombie reaches the house
- `state`  out  8  one-hot: I=8'h80, L1=8'h40, NL2=8'h20, L2=8'h10, NL3=8'h08, L3=8'h04, DoneL=8'h02, DoneW=8'h01
- `level`  out  2  0 in I/DoneL/DoneW, 1 in L1, 2 in NL2/L2, 3 in NL3/L3
- `spawn_en`  out  1  high only in L1, L2, L3
- `level_kills`  out  16  kills in current level
- `zombies_killed`  out  16  kills since leaving I
- `pause_left`  out  8  frame ticks remaining in NL2/NL3, else 0

## Operation
- I: on `select_pulse` -> L1; clears `level_kills` and `zombies_killed`.
- L1/L2/L3: each `kill_pulse` increments `level_kills` and `zombies_killed` (both saturate at 16'hFFFF, no wrap). When the increment makes `level_kills` equal KILLS_Ln: L1 -> NL2, L2 -> NL3, L3 -> DoneW. `breach_pulse` -> DoneL.
- Breach and threshold-reaching kill in the same cycle: DoneL wins; kill is still counted in `zombies_killed`.
- `select_pulse` ignored in L1/L2/L3.
- NL2/NL3: on entry `pause_left` loads PAUSE_FRAMES and `level_kills` clears to 0. Each `frame_tick` decrements `pause_left`; on the tick taking it to 0, or on `select_pulse` (skip), advance NL2 -> L2, NL3 -> L3. `kill_pulse` and `breach_pulse` ignored.
- DoneL/DoneW: counters hold (final score shown). `select_pulse` -> I; nothing else leaves.
- `state` is always exactly one-hot; any non-one-hot register value (SEU/illegal) recovers to I on the next clock.

## Timing
- All outputs registered; reset (RESET_N low, async) forces `state`=8'h80, `level`=0, `spawn_en`=0, all counters and `pause_left`=0. Release is synchronous to next `ClkPort` edge.
- Input pulse sampled on edge N -> new `state`/counter values visible after edge N (1-cycle latency). `spawn_en` and `level` change in the same cycle as `state`.
- Counters update on the same edge as the transition they cause.
- PAUSE_FRAMES=0: NL2/NL3 exit on the first `frame_tick` or `select_pulse`.
- Inputs are pulses; a level held high counts once per cycle (caller's responsibility to pulse).
- Reset mid-level: immediate return to I, score lost.

## Test plan
- Reset: assert RESET_N=0 mid-L2 -> `state`=8'h80, `zombies_killed`=0, `spawn_en`=0 without waiting for a clock edge.
- Full win: select, 10 kills, 120 frame ticks, 15 kills, select (skip), 20 kills -> state sequence 80,40,20,10,08,04,01; `zombies_killed`=45; `spawn_en` low in 20/08/01.
- Lose: select, 3 kills, breach -> `state`=8'h02, `zombies_killed`=3 held; select -> 8'h80, counters unchanged until next select clears them.
- Tie: in L1 with 9 kills, kill_pulse and breach_pulse same cycle -> `state`=8'h02, `zombies_killed`=10.
- Pause: enter NL2, 119 frame ticks -> still 8'h20, `pause_left`=1; kill/breach pulses ignored; 120th tick -> 8'h10, `level_kills`=0.
- Illegal state: force `state` register to 8'h41 -> 8'h80 after one clock.
